// File: rtl/axis_insert_arbiter.sv
// Round-robin arbiter that lets NUM_SRC header+payload streams take turns
// on one shared insert-header engine, one whole packet per grant.
module axis_insert_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_SRC      = 4
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic [NUM_SRC-1:0]              s_hdr_tvalid,
  output logic [NUM_SRC-1:0]              s_hdr_tready,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_hdr_tdata,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_hdr_tkeep,

  input  logic [NUM_SRC-1:0]              s_pay_tvalid,
  output logic [NUM_SRC-1:0]              s_pay_tready,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_pay_tdata,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_pay_tkeep,
  input  logic [NUM_SRC-1:0]              s_pay_tlast,

  output logic                            m_hdr_tvalid,
  input  logic                            m_hdr_tready,
  output logic [DATA_WD-1:0]              m_hdr_tdata,
  output logic [DATA_BYTE_WD-1:0]         m_hdr_tkeep,

  output logic                            m_pay_tvalid,
  input  logic                            m_pay_tready,
  output logic [DATA_WD-1:0]              m_pay_tdata,
  output logic [DATA_BYTE_WD-1:0]         m_pay_tkeep,
  output logic                            m_pay_tlast,

  output logic [3:0]                      grant_idx,
  output logic                            busy,
  output logic [15:0]                     pkt_cnt
);

  localparam int MAX_SRC = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  // Sources are padded out to 16 so the 4-bit grant can index them directly.
  logic [MAX_SRC-1:0]      hdr_valid_pad;
  logic [MAX_SRC-1:0]      pay_valid_pad;
  logic [MAX_SRC-1:0]      pay_last_pad;
  logic [DATA_WD-1:0]      hdr_data_arr [MAX_SRC];
  logic [DATA_BYTE_WD-1:0] hdr_keep_arr [MAX_SRC];
  logic [DATA_WD-1:0]      pay_data_arr [MAX_SRC];
  logic [DATA_BYTE_WD-1:0] pay_keep_arr [MAX_SRC];

  generate
    for (genvar gi = 0; gi < MAX_SRC; gi++) begin : g_pad
      if (gi < NUM_SRC) begin : g_src
        assign hdr_valid_pad[gi] = s_hdr_tvalid[gi];
        assign pay_valid_pad[gi] = s_pay_tvalid[gi];
        assign pay_last_pad[gi]  = s_pay_tlast[gi];
        assign hdr_data_arr[gi]  = s_hdr_tdata[gi*DATA_WD +: DATA_WD];
        assign hdr_keep_arr[gi]  = s_hdr_tkeep[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
        assign pay_data_arr[gi]  = s_pay_tdata[gi*DATA_WD +: DATA_WD];
        assign pay_keep_arr[gi]  = s_pay_tkeep[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
      end else begin : g_none
        assign hdr_valid_pad[gi] = 1'b0;
        assign pay_valid_pad[gi] = 1'b0;
        assign pay_last_pad[gi]  = 1'b0;
        assign hdr_data_arr[gi]  = '0;
        assign hdr_keep_arr[gi]  = '0;
        assign pay_data_arr[gi]  = '0;
        assign pay_keep_arr[gi]  = '0;
      end
    end
  endgenerate

  // Candidate k is the source visited k-th when searching from rr_ptr.
  logic [4:0] cand_sum [NUM_SRC];
  logic [3:0] cand_idx [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, rr_ptr_q} + 5'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= 5'(NUM_SRC)) ?
                            4'(cand_sum[gi] - 5'(NUM_SRC)) : cand_sum[gi][3:0];
    end
  endgenerate

  logic       pick_found;
  logic [3:0] pick_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    // Walk backwards so the nearest requester to rr_ptr wins.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (hdr_valid_pad[cand_idx[k]]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  logic in_head;
  logic in_body;

  assign in_head = !rst && (state_q == ST_HEAD);
  assign in_body = !rst && (state_q == ST_BODY);

  assign m_hdr_tvalid = in_head && hdr_valid_pad[grant_q];
  assign m_hdr_tdata  = m_hdr_tvalid ? hdr_data_arr[grant_q] : '0;
  assign m_hdr_tkeep  = m_hdr_tvalid ? hdr_keep_arr[grant_q] : '0;

  assign m_pay_tvalid = in_body && pay_valid_pad[grant_q];
  assign m_pay_tdata  = m_pay_tvalid ? pay_data_arr[grant_q] : '0;
  assign m_pay_tkeep  = m_pay_tvalid ? pay_keep_arr[grant_q] : '0;
  assign m_pay_tlast  = m_pay_tvalid && pay_last_pad[grant_q];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
      assign s_hdr_tready[gi] = in_head && m_hdr_tready && (grant_q == 4'(gi));
      assign s_pay_tready[gi] = in_body && m_pay_tready && (grant_q == 4'(gi));
    end
  endgenerate

  assign grant_idx = grant_q;
  assign busy      = !rst && (state_q != ST_IDLE);
  assign pkt_cnt   = pkt_cnt_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (m_hdr_tvalid && m_hdr_tready) begin
          state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        if (m_pay_tvalid && m_pay_tready && m_pay_tlast) begin
          state_d   = ST_IDLE;
          rr_ptr_d  = (grant_q == 4'(NUM_SRC - 1)) ? 4'd0 : grant_q + 4'd1;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 4'd0;
      rr_ptr_q  <= 4'd0;
      pkt_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

endmodule
